// File: rtl/tc7_pkg.sv
// Shared definitions for the mod-7 thermometer-code datapath: legal code table
// and conversions between TC codes and binary values.
package tc7_pkg;

  localparam int TC7_W = 6;
  localparam int MOD7  = 7;

  localparam logic [TC7_W-1:0] TC7_CODE [MOD7] = '{
    6'b000000, 6'b000001, 6'b000011, 6'b000111,
    6'b001111, 6'b011111, 6'b111111
  };

  typedef struct packed {
    logic [TC7_W-1:0] tc;
    logic [2:0]       bin;
    logic             err;
  } tc7_sum_t;

  function automatic logic tc7_is_legal(input logic [TC7_W-1:0] code);
    logic hit;
    hit = 1'b0;
    for (int v = 0; v < MOD7; v++)
      if (code == TC7_CODE[v]) hit = 1'b1;
    return hit;
  endfunction

  // Illegal codes decode to 0 so downstream arithmetic never sees X.
  function automatic logic [2:0] tc7_to_val(input logic [TC7_W-1:0] code);
    logic [2:0] val;
    val = '0;
    for (int v = 0; v < MOD7; v++)
      if (code == TC7_CODE[v]) val = 3'(v);
    return val;
  endfunction

  function automatic logic [TC7_W-1:0] val_to_tc7(input logic [2:0] val);
    logic [TC7_W-1:0] code;
    code = '0;
    for (int v = 0; v < MOD7; v++)
      if (val == 3'(v)) code = TC7_CODE[v];
    return code;
  endfunction

endpackage

// File: rtl/tc7_mod_add.sv
// Combinational mod-7 adder on thermometer-coded operands; flags illegal codes
// and forces a zero result in that case.
module tc7_mod_add
  import tc7_pkg::*;
(
  input  logic [TC7_W-1:0] a,
  input  logic [TC7_W-1:0] b,
  output logic [TC7_W-1:0] sum_tc,
  output logic [2:0]       sum_bin,
  output logic             err
);

  logic [2:0] va;
  logic [2:0] vb;
  logic [3:0] raw;
  logic [2:0] wrapped;

  always_comb begin
    va      = tc7_to_val(a);
    vb      = tc7_to_val(b);
    raw     = {1'b0, va} + {1'b0, vb};
    // Sum is at most 12, so a single conditional subtract reduces it mod 7.
    wrapped = (raw >= 4'(MOD7)) ? 3'(raw - 4'(MOD7)) : raw[2:0];
    err     = !(tc7_is_legal(a) && tc7_is_legal(b));
    sum_bin = err ? 3'b000 : wrapped;
    sum_tc  = val_to_tc7(sum_bin);
  end

endmodule

// File: rtl/tc7_add_arbiter.sv
// Round-robin sharing of one mod-7 TC adder among NREQ requesters, with a
// single-entry result register and a saturating malformed-operand counter.
module tc7_add_arbiter
  import tc7_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int ECW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [TC7_W*NREQ-1:0]   req_a,
  input  logic [TC7_W*NREQ-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [IDW-1:0]          res_id,
  output logic [TC7_W-1:0]        res_tc,
  output logic [2:0]              res_bin,
  output logic                    res_err,
  output logic [ECW-1:0]          err_cnt
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] cnt);
    return (&cnt) ? cnt : cnt + ECW'(1);
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
    return (g == LAST_ID) ? '0 : g + IDW'(1);
  endfunction

  logic [IDW-1:0]   ptr;
  logic             vld_p1;
  logic [IDW-1:0]   id_p1;
  tc7_sum_t         sum_p1;
  logic [ECW-1:0]   cnt;

  logic             free;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [TC7_W-1:0] op_a;
  logic [TC7_W-1:0] op_b;
  logic             xfer;
  tc7_sum_t         sum_p0;
  int               j;

  // Stage p0: arbitration and operand select
  assign free = !vld_p1 || res_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    op_a    = '0;
    op_b    = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (free && !gnt_vld && req_valid[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(j);
        op_a    = req_a[TC7_W*j +: TC7_W];
        op_b    = req_b[TC7_W*j +: TC7_W];
      end
    end
  end

  assign xfer = gnt_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  tc7_mod_add u_add (
    .a       (op_a),
    .b       (op_b),
    .sum_tc  (sum_p0.tc),
    .sum_bin (sum_p0.bin),
    .err     (sum_p0.err)
  );

  // Stage p1: result register, pointer and error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      id_p1  <= '0;
      sum_p1 <= '0;
      ptr    <= '0;
      cnt    <= '0;
    end else if (xfer) begin
      vld_p1 <= 1'b1;
      id_p1  <= gnt_idx;
      sum_p1 <= sum_p0;
      ptr    <= next_ptr(gnt_idx);
      if (sum_p0.err) cnt <= sat_inc(cnt);
    end else if (res_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign res_valid = vld_p1;
  assign res_id    = id_p1;
  assign res_tc    = sum_p1.tc;
  assign res_bin   = sum_p1.bin;
  assign res_err   = sum_p1.err;
  assign err_cnt   = cnt;

endmodule

// File: tb/tb_tc7_add_arbiter.sv
// Self-checking bench for tc7_add_arbiter: directed scenarios plus random
// traffic, all compared against a value-level reference model.
module tb_tc7_add_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int ECW  = 2;
  localparam int CMAX = (1 << ECW) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [6*NREQ-1:0]    req_a = '0;
  logic [6*NREQ-1:0]    req_b = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [IDW-1:0]       res_id;
  logic [5:0]           res_tc;
  logic [2:0]           res_bin;
  logic                 res_err;
  logic [ECW-1:0]       err_cnt;

  always #5 clk = ~clk;

  tc7_add_arbiter #(.NREQ(NREQ), .IDW(IDW), .ECW(ECW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_tc(res_tc), .res_bin(res_bin), .res_err(res_err),
    .err_cnt(err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic m_valid;
  int   m_id, m_bin, m_ptr, m_cnt, last_g;
  logic m_err;

  function automatic int code_val(input logic [5:0] c);
    for (int v = 0; v < 7; v++)
      if (c == 6'((1 << v) - 1)) return v;
    return -1;
  endfunction

  function automatic logic [5:0] val_code(input int v);
    return 6'((1 << v) - 1);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 0; m_bin = 0; m_err = 1'b0;
    m_ptr = 0; m_cnt = 0; last_g = -1;
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [5:0] b);
    req_a[6*i +: 6] = a;
    req_b[6*i +: 6] = b;
  endtask

  // One clock: check arbitration, advance model at the edge, check result.
  task automatic step();
    int g, va, vb;
    logic [NREQ-1:0] exp_rdy;
    #1;
    g = -1;
    if (!m_valid || res_ready)
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    va = (g >= 0) ? code_val(req_a[6*g +: 6]) : 0;
    vb = (g >= 0) ? code_val(req_b[6*g +: 6]) : 0;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_bad++; $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
    end
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1; m_id = g; m_ptr = (g + 1) % NREQ; last_g = g;
      if (va < 0 || vb < 0) begin
        m_err = 1'b1; m_bin = 0;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_err = 1'b0; m_bin = (va + vb) % 7;
      end
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    #1;
    n_cmp++;
    if (res_valid !== m_valid) begin
      n_bad++; $display("FAIL res_valid: got %b want %b", res_valid, m_valid);
    end
    n_cmp++;
    if (res_id !== IDW'(m_id)) begin
      n_bad++; $display("FAIL res_id: got %0d want %0d", res_id, m_id);
    end
    n_cmp++;
    if (res_bin !== 3'(m_bin)) begin
      n_bad++; $display("FAIL res_bin: got %0d want %0d", res_bin, m_bin);
    end
    n_cmp++;
    if (res_tc !== val_code(m_bin)) begin
      n_bad++; $display("FAIL res_tc: got %b want %b", res_tc, val_code(m_bin));
    end
    n_cmp++;
    if (res_err !== m_err) begin
      n_bad++; $display("FAIL res_err: got %b want %b", res_err, m_err);
    end
    n_cmp++;
    if (err_cnt !== ECW'(m_cnt)) begin
      n_bad++; $display("FAIL err_cnt: got %0d want %0d", err_cnt, m_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    n_cmp++;
    if ({res_valid, res_id, res_tc, res_bin, res_err, err_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b id=%0d tc=%b bin=%0d err=%b cnt=%0d want all 0",
               res_valid, res_id, res_tc, res_bin, res_err, err_cnt);
    end
    req_valid = '0;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    set_req(1, 6'b000111, 6'b001111);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    n_cmp++;
    if ({res_valid, res_id, res_tc, res_bin, res_err} !== {1'b1, 2'd1, 6'b0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL single: got v=%b id=%0d tc=%b bin=%0d err=%b want v=1 id=1 tc=000000 bin=0 err=0",
               res_valid, res_id, res_tc, res_bin, res_err);
    end
    step();
  endtask

  task automatic test_round_robin();
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    test_reset();
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 6'b111111, 6'b111111);
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      step();
      n_cmp++;
      if (res_id !== IDW'(exp_ids[n]) || res_bin !== 3'd5 || res_tc !== 6'b011111) begin
        n_bad++;
        $display("FAIL rr_%0d: got id=%0d bin=%0d tc=%b want id=%0d bin=5 tc=011111",
                 n, res_id, res_bin, res_tc, exp_ids[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] held_tc;
    logic [IDW-1:0] held_id;
    set_req(2, 6'b000011, 6'b000001);
    req_valid = 4'b0100;
    res_ready = 1'b0;
    held_tc = val_code(m_bin);
    held_id = IDW'(m_id);
    for (int n = 0; n < 3; n++) step();
    n_cmp++;
    if (res_tc !== held_tc || res_id !== held_id || res_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hold: got v=%b id=%0d tc=%b want v=1 id=%0d tc=%b",
               res_valid, res_id, res_tc, held_id, held_tc);
    end
    res_ready = 1'b1;
    step();
    n_cmp++;
    if (res_id !== 2'd2 || res_bin !== 3'd3) begin
      n_bad++; $display("FAIL bp_drain: got id=%0d bin=%0d want id=2 bin=3", res_id, res_bin);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_error_sat();
    res_ready = 1'b1;
    set_req(0, 6'b000101, 6'b000001);
    req_valid = 4'b0001;
    step();
    n_cmp++;
    if (err_cnt !== 2'd1 || res_err !== 1'b1 || res_bin !== 3'd0 || res_tc !== 6'b0) begin
      n_bad++;
      $display("FAIL err_first: got cnt=%0d err=%b bin=%0d tc=%b want cnt=1 err=1 bin=0 tc=000000",
               err_cnt, res_err, res_bin, res_tc);
    end
    for (int n = 0; n < 4; n++) step();
    n_cmp++;
    if (err_cnt !== 2'd3) begin
      n_bad++; $display("FAIL err_sat: got %0d want 3", err_cnt);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_sweep();
    res_ready = 1'b1;
    req_valid = 4'b1000;
    for (int a = 0; a < 7; a++)
      for (int b = 0; b < 7; b++) begin
        set_req(3, val_code(a), val_code(b));
        step();
        n_cmp++;
        if (res_bin !== 3'((a + b) % 7) || res_tc !== val_code((a + b) % 7) || res_err !== 1'b0) begin
          n_bad++;
          $display("FAIL sweep_%0d_%0d: got bin=%0d tc=%b err=%b want bin=%0d",
                   a, b, res_bin, res_tc, res_err, (a + b) % 7);
        end
      end
    req_valid = '0;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      req_valid = NREQ'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        logic [5:0] a, b;
        a = ($urandom_range(0, 3) != 0) ? val_code($urandom_range(0, 6)) : 6'($urandom);
        b = ($urandom_range(0, 3) != 0) ? val_code($urandom_range(0, 6)) : 6'($urandom);
        set_req(i, a, b);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 6'b010101, 6'b000000);
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || err_cnt !== '0 || req_ready !== '0) begin
      n_bad++;
      $display("FAIL async_rst: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=0",
               res_valid, err_cnt, req_ready);
    end
    model_reset();
    req_valid = 4'b1100;
    set_req(2, 6'b000001, 6'b000001);
    set_req(3, 6'b000001, 6'b000011);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    step();
    n_cmp++;
    if (last_g != 2 || res_id !== 2'd2 || res_bin !== 3'd2) begin
      n_bad++; $display("FAIL post_rst_grant: got id=%0d bin=%0d want id=2 bin=2", res_id, res_bin);
    end
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_error_sat();
    test_sweep();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
